ftrans_rot: RTL and testbench
=============================

# ftrans_rot

Parametrised radix-2² inter-stage twiddle rotator for the pipelined FFT.
- Computes the twiddle index from the sample's position address and multiplies each complex sample by W_N^idx, where N = 2^FFT_STG.
- Replaces the fixed-width, fixed-size rotator with generic data and twiddle widths and a per-sample inverse (IFFT) mode.
- Adds an exact unity-twiddle bypass, saturation with an overflow flag, and valid-gated data registers.
- Sits between the type-I and type-II butterfly stages of each radix-2² pair.

## Interface
- FFT_STG, 7: log2 of the FFT size N; legal range 3..11.
- DATA_W, 16: width of the real and imaginary parts of the samples, signed two's complement.
- TW_W, 16: width of the twiddle real and imaginary parts, signed; full scale is 2^(TW_W-1)-1.
- MULT_DLY, 2: number of multiplier pipeline stages, ≥1.
- iclk  in  1  clock; all logic is on the rising edge.
- irst  in  1  reset; asynchronous, active-high.
- ien  in  1  input sample valid.
- iinv  in  1  inverse mode; sampled with ien and carried with the sample.
- iaddr  in  FFT_STG  sample position address.
- idata  in  2*DATA_W  input sample, {re, im}.
- oen  out  1  output valid.
- oaddr  out  FFT_STG  iaddr delayed with its sample.
- odata  out  2*DATA_W  rotated sample, {re, im}.
- oovf  out  1  saturation occurred on this output sample; qualified by oen.

## Operation
- Address decode:
  - k1 = iaddr[FFT_STG-1], k2 = iaddr[FFT_STG-2], n3 = iaddr[FFT_STG-3:0].
  - idx = (k1 + 2·k2)·n3, computed FFT_STG bits wide; the maximum value 3·(N/4-1) never wraps.
- Twiddle:
  - Forward: W = (C, −S), with C = round(cos(2π·idx/N)·(2^(TW_W-1)-1)) and S the corresponding sine.
  - iinv=1: W = (C, +S), i.e. the conjugate.
- Product, for input a + jb:
  - re = a·C − b·Wim, im = b·C + a·Wim.
  - Full precision DATA_W+TW_W+1 bits, then arithmetic right shift by TW_W−1.
  - Rounding is set by the configuration macro (see Configuration).
- Saturation:
  - Each part is clamped to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
  - oovf = 1 if either part clamped.
- Unity bypass: idx==0 passes the input through exactly, with identical latency and oovf=0. There is no full-scale gain loss.
- Per-stage valid bits travel with the data. Data, address and mode registers load only when their stage's valid bit is 1. odata, oaddr and oovf therefore hold the last valid result while oen=0.
- Reset: all valid bits, oen, oaddr, odata and oovf go to 0 immediately. Samples in flight are discarded; no output emerges from them after release.

## Timing
- Latency LAT = MULT_DLY + 3 cycles from an ien=1 edge to oen=1. Stages:
  - input/index register
  - twiddle lookup register
  - MULT_DLY multiplier stages
  - round/saturate output register
- Full throughput: one sample per cycle. Back-to-back ien produces back-to-back oen in the same order.
- Gaps in ien reproduce as identical gaps in oen; there is no backpressure.
- iinv may change on any sample with no bubble.
- irst deassertion: first valid ien accepted on the next rising edge.

## Configuration
- FTROT_ROUND_EN defined: round half-up. Add 2^(TW_W-2) before the shift; any carry into the saturation range raises oovf.
- FTROT_ROUND_EN undefined: truncation, i.e. floor by arithmetic shift. This saves one adder per part.

## Structure
- Package ftrot_pkg holds:
  - the idx computation function
  - the saturate function
  - the twiddle-scale constant 2^(TW_W-1)-1
- Sub-module ftwiddle_rom:
  - Parameters FFT_STG and TW_W.
  - Registered output {C, S} for idx.
  - Table filled at elaboration from the cos/sin of 2π·k/N, k = 0..N−1.
- Inverse conjugation is applied outside the ROM by negating S.

## Test plan
FFT_STG=4, DATA_W=16, TW_W=16, MULT_DLY=2, so LAT=5 and C/S full scale is 32767.
- Bypass: iaddr=4'b0001 (k1=k2=0, idx 0), idata=(1000,−2000) → 5 cycles later oen=1, odata=(1000,−2000), oovf=0.
- Rounding on W=−j:
  - Input: iaddr=4'b0110 (idx 4, W=−j), idata=(0,1000), iinv=0.
  - With FTROT_ROUND_EN → odata=(1000,0).
  - Without FTROT_ROUND_EN → odata=(999,0).
- Inverse mode:
  - Input: same iaddr, idata=(1000,0), iinv=1 (W=+j).
  - With FTROT_ROUND_EN → (0,1000).
  - Without FTROT_ROUND_EN → (0,999).
- Saturation:
  - Input: iaddr=4'b1010 (idx 2, C=S=23170), idata=(−32768,−32768).
  - Response: odata=(−32768,0), oovf=1.
- Streaming:
  - 16 consecutive samples with iaddr 0..15, then a 3-cycle gap, then 2 more samples.
  - Response: oen high for cycles 5..20, a 3-cycle gap, then 2 cycles high; oaddr in order; odata holds its value during the gap.
- Reset mid-stream: assert irst for 1 cycle with 3 samples in flight → oen, oaddr, odata and oovf are 0 at once, and oen stays 0 until new input arrives.

Source files
------------

// File: rtl/ftrot_pkg.sv
// Shared helpers for the inter-stage twiddle rotator: twiddle index decode,
// twiddle table generation, scale constant and output saturation.
`timescale 1ns/1ps
package ftrot_pkg;

  localparam real TW_PI = 3.14159265358979323846;

  function automatic int tw_scale(input int tw_w);
    return (1 << (tw_w - 1)) - 1;
  endfunction

  // idx = (k1 + 2*k2) * n3 from the top two address bits and the remainder.
  function automatic int unsigned tw_idx(input int unsigned addr, input int unsigned stg);
    int unsigned k1;
    int unsigned k2;
    int unsigned n3;
    k1 = (addr >> (stg - 1)) & 32'd1;
    k2 = (addr >> (stg - 2)) & 32'd1;
    n3 = addr & ((32'd1 << (stg - 2)) - 32'd1);
    return (k1 + 32'd2 * k2) * n3;
  endfunction

  function automatic int tw_round(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int tw_cos(input int k, input int stg, input int tw_w);
    real ang;
    ang = 2.0 * TW_PI * real'(k) / real'(1 << stg);
    return tw_round($cos(ang) * real'(tw_scale(tw_w)));
  endfunction

  function automatic int tw_sin(input int k, input int stg, input int tw_w);
    real ang;
    ang = 2.0 * TW_PI * real'(k) / real'(1 << stg);
    return tw_round($sin(ang) * real'(tw_scale(tw_w)));
  endfunction

  // Clamp a wide signed value into a dw-bit signed range, flagging any clamp.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                    input int dw,
                                                    output logic ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    if (v > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (v < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/ftwiddle_rom.sv
// Twiddle table {C, S} = round({cos, sin}(2*pi*k/N) * full scale), k = 0..N-1,
// with a registered read port that loads only on valid lookups.
`timescale 1ns/1ps
module ftwiddle_rom
  import ftrot_pkg::*;
#(
  parameter int FFT_STG = 7,
  parameter int TW_W    = 16
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                ien,
  input  logic [FFT_STG-1:0]  iidx,
  output logic [2*TW_W-1:0]   ocs
);

  localparam int N = 1 << FFT_STG;

  logic [2*TW_W-1:0] w_tab [N];
  logic [2*TW_W-1:0] r_cs;

  for (genvar gi = 0; gi < N; gi++) begin : g_tab
    assign w_tab[gi] = {TW_W'(tw_cos(gi, FFT_STG, TW_W)), TW_W'(tw_sin(gi, FFT_STG, TW_W))};
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_cs <= '0;
    end else if (ien) begin
      r_cs <= w_tab[iidx];
    end
  end

  assign ocs = r_cs;

endmodule

// File: rtl/ftrans_rot.sv
// Radix-2^2 inter-stage twiddle rotator: out = in * W_N^idx (conjugate when iinv).
// Define FTROT_ROUND_EN for round-half-up before the shift; otherwise truncate.
`timescale 1ns/1ps
module ftrans_rot
  import ftrot_pkg::*;
#(
  parameter int FFT_STG  = 7,
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16,
  parameter int MULT_DLY = 2
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 ien,
  input  logic                 iinv,
  input  logic [FFT_STG-1:0]   iaddr,
  input  logic [2*DATA_W-1:0]  idata,
  output logic                 oen,
  output logic [FFT_STG-1:0]   oaddr,
  output logic [2*DATA_W-1:0]  odata,
  output logic                 oovf
);

  localparam int PW = DATA_W + TW_W + 1;
  localparam int L  = MULT_DLY - 1;

  // Stage 0: input capture and index decode
  logic                 r_s0_vld;
  logic                 r_s0_inv;
  logic                 r_s0_byp;
  logic [FFT_STG-1:0]   r_s0_addr;
  logic [FFT_STG-1:0]   r_s0_idx;
  logic [2*DATA_W-1:0]  r_s0_data;
  logic [FFT_STG-1:0]   w_idx;

  assign w_idx = FFT_STG'(tw_idx(32'(iaddr), FFT_STG));

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_s0_vld  <= 1'b0;
      r_s0_inv  <= 1'b0;
      r_s0_byp  <= 1'b0;
      r_s0_addr <= '0;
      r_s0_idx  <= '0;
      r_s0_data <= '0;
    end else begin
      r_s0_vld <= ien;
      if (ien) begin
        r_s0_inv  <= iinv;
        r_s0_byp  <= (w_idx == '0);
        r_s0_addr <= iaddr;
        r_s0_idx  <= w_idx;
        r_s0_data <= idata;
      end
    end
  end

  // Stage 1: twiddle lookup, sideband travels alongside the ROM register
  logic [2*TW_W-1:0]    w_cs;
  logic                 r_s1_vld;
  logic                 r_s1_inv;
  logic                 r_s1_byp;
  logic [FFT_STG-1:0]   r_s1_addr;
  logic [2*DATA_W-1:0]  r_s1_data;

  ftwiddle_rom #(
    .FFT_STG (FFT_STG),
    .TW_W    (TW_W)
  ) u_rom (
    .iclk (iclk),
    .irst (irst),
    .ien  (r_s0_vld),
    .iidx (r_s0_idx),
    .ocs  (w_cs)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_s1_vld  <= 1'b0;
      r_s1_inv  <= 1'b0;
      r_s1_byp  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= r_s0_vld;
      if (r_s0_vld) begin
        r_s1_inv  <= r_s0_inv;
        r_s1_byp  <= r_s0_byp;
        r_s1_addr <= r_s0_addr;
        r_s1_data <= r_s0_data;
      end
    end
  end

  // Complex multiply; inverse mode conjugates by flipping the sign of S
  logic signed [TW_W-1:0]          w_c;
  logic signed [TW_W-1:0]          w_s;
  logic signed [TW_W-1:0]          w_wim;
  logic signed [DATA_W-1:0]        w_a;
  logic signed [DATA_W-1:0]        w_b;
  logic signed [DATA_W+TW_W-1:0]   w_p_ac;
  logic signed [DATA_W+TW_W-1:0]   w_p_bw;
  logic signed [DATA_W+TW_W-1:0]   w_p_bc;
  logic signed [DATA_W+TW_W-1:0]   w_p_aw;
  logic signed [PW-1:0]            w_re_full;
  logic signed [PW-1:0]            w_im_full;

  assign w_c       = w_cs[2*TW_W-1:TW_W];
  assign w_s       = w_cs[TW_W-1:0];
  assign w_wim     = r_s1_inv ? w_s : -w_s;
  assign w_a       = r_s1_data[2*DATA_W-1:DATA_W];
  assign w_b       = r_s1_data[DATA_W-1:0];
  assign w_p_ac    = w_a * w_c;
  assign w_p_bw    = w_b * w_wim;
  assign w_p_bc    = w_b * w_c;
  assign w_p_aw    = w_a * w_wim;
  assign w_re_full = PW'(w_p_ac) - PW'(w_p_bw);
  assign w_im_full = PW'(w_p_bc) + PW'(w_p_aw);

  logic                 r_m_vld  [MULT_DLY];
  logic                 r_m_byp  [MULT_DLY];
  logic [FFT_STG-1:0]   r_m_addr [MULT_DLY];
  logic [2*DATA_W-1:0]  r_m_data [MULT_DLY];
  logic signed [PW-1:0] r_m_re   [MULT_DLY];
  logic signed [PW-1:0] r_m_im   [MULT_DLY];

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      for (int i = 0; i < MULT_DLY; i++) begin
        r_m_vld[i]  <= 1'b0;
        r_m_byp[i]  <= 1'b0;
        r_m_addr[i] <= '0;
        r_m_data[i] <= '0;
        r_m_re[i]   <= '0;
        r_m_im[i]   <= '0;
      end
    end else begin
      r_m_vld[0] <= r_s1_vld;
      if (r_s1_vld) begin
        r_m_byp[0]  <= r_s1_byp;
        r_m_addr[0] <= r_s1_addr;
        r_m_data[0] <= r_s1_data;
        r_m_re[0]   <= w_re_full;
        r_m_im[0]   <= w_im_full;
      end
      for (int i = 1; i < MULT_DLY; i++) begin
        r_m_vld[i] <= r_m_vld[i-1];
        if (r_m_vld[i-1]) begin
          r_m_byp[i]  <= r_m_byp[i-1];
          r_m_addr[i] <= r_m_addr[i-1];
          r_m_data[i] <= r_m_data[i-1];
          r_m_re[i]   <= r_m_re[i-1];
          r_m_im[i]   <= r_m_im[i-1];
        end
      end
    end
  end

  // Round/shift/saturate
  logic signed [PW-1:0]     w_re_rnd;
  logic signed [PW-1:0]     w_im_rnd;
  logic signed [PW-1:0]     w_re_sh;
  logic signed [PW-1:0]     w_im_sh;
  logic [DATA_W-1:0]        w_re_sat;
  logic [DATA_W-1:0]        w_im_sat;
  logic                     w_ovf_re;
  logic                     w_ovf_im;

`ifdef FTROT_ROUND_EN
  localparam logic signed [PW-1:0] RND_HALF = PW'(1) << (TW_W - 2);
  assign w_re_rnd = r_m_re[L] + RND_HALF;
  assign w_im_rnd = r_m_im[L] + RND_HALF;
`else
  assign w_re_rnd = r_m_re[L];
  assign w_im_rnd = r_m_im[L];
`endif

  assign w_re_sh = w_re_rnd >>> (TW_W - 1);
  assign w_im_sh = w_im_rnd >>> (TW_W - 1);

  always_comb begin
    w_ovf_re = 1'b0;
    w_ovf_im = 1'b0;
    w_re_sat = DATA_W'(sat_clamp(64'(w_re_sh), DATA_W, w_ovf_re));
    w_im_sat = DATA_W'(sat_clamp(64'(w_im_sh), DATA_W, w_ovf_im));
  end

  logic                 r_oen;
  logic [FFT_STG-1:0]   r_oaddr;
  logic [2*DATA_W-1:0]  r_odata;
  logic                 r_oovf;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_oen   <= 1'b0;
      r_oaddr <= '0;
      r_odata <= '0;
      r_oovf  <= 1'b0;
    end else begin
      r_oen <= r_m_vld[L];
      if (r_m_vld[L]) begin
        r_oaddr <= r_m_addr[L];
        if (r_m_byp[L]) begin
          r_odata <= r_m_data[L];
          r_oovf  <= 1'b0;
        end else begin
          r_odata <= {w_re_sat, w_im_sat};
          r_oovf  <= w_ovf_re | w_ovf_im;
        end
      end
    end
  end

  assign oen   = r_oen;
  assign oaddr = r_oaddr;
  assign odata = r_odata;
  assign oovf  = r_oovf;

endmodule

// File: tb/tb_ftrans_rot.sv
// Directed bench for ftrans_rot at FFT_STG=4, DATA_W=16, TW_W=16, MULT_DLY=2.
`timescale 1ns/1ps
module tb_ftrans_rot;

  logic        clk = 1'b0;
  logic        rst;
  logic        ien;
  logic        iinv;
  logic [3:0]  iaddr;
  logic [31:0] idata;
  logic        oen;
  logic [3:0]  oaddr;
  logic [31:0] odata;
  logic        oovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ftrans_rot #(
    .FFT_STG  (4),
    .DATA_W   (16),
    .TW_W     (16),
    .MULT_DLY (2)
  ) dut (
    .iclk  (clk),
    .irst  (rst),
    .ien   (ien),
    .iinv  (iinv),
    .iaddr (iaddr),
    .idata (idata),
    .oen   (oen),
    .oaddr (oaddr),
    .odata (odata),
    .oovf  (oovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint rnd(input real v);
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction

  // Reference rotation straight from the formulas, N = 16, full scale 32767.
  function automatic logic [31:0] model(input int addr, input int a, input int b,
                                        input bit inv, output bit ovf);
    int     k1, k2, n3, idx;
    real    ang;
    longint c, s, wim, re, im;
    k1  = (addr >> 3) & 1;
    k2  = (addr >> 2) & 1;
    n3  = addr & 3;
    idx = (k1 + 2 * k2) * n3;
    ovf = 1'b0;
    if (idx == 0) return {16'(a), 16'(b)};
    ang = 2.0 * 3.14159265358979 * real'(idx) / 16.0;
    c   = rnd($cos(ang) * 32767.0);
    s   = rnd($sin(ang) * 32767.0);
    wim = inv ? s : -s;
    re  = longint'(a) * c - longint'(b) * wim;
    im  = longint'(b) * c + longint'(a) * wim;
`ifdef FTROT_ROUND_EN
    re  = re + 16384;
    im  = im + 16384;
`endif
    re = re >>> 15;
    im = im >>> 15;
    if (re > 32767) begin re = 32767; ovf = 1'b1; end
    else if (re < -32768) begin re = -32768; ovf = 1'b1; end
    if (im > 32767) begin im = 32767; ovf = 1'b1; end
    else if (im < -32768) begin im = -32768; ovf = 1'b1; end
    return {16'(re), 16'(im)};
  endfunction

  // One isolated sample: oen must stay low after 4 edges and rise on the 5th.
  task automatic single(input string tag, input logic [3:0] a, input logic [31:0] d,
                        input logic inv, input logic [31:0] exp_d, input logic exp_ovf);
    ien = 1'b1; iaddr = a; idata = d; iinv = inv;
    step();
    ien = 1'b0;
    step(); step(); step();
    chk({tag, "_early_oen"}, 32'(oen), 32'd0);
    step();
    chk({tag, "_oen"},   32'(oen),   32'd1);
    chk({tag, "_oaddr"}, 32'(oaddr), 32'(a));
    chk({tag, "_odata"}, odata,      exp_d);
    chk({tag, "_oovf"},  32'(oovf),  32'(exp_ovf));
  endtask

  logic [3:0]  s_addr [21];
  logic [31:0] s_dat  [21];
  logic [31:0] s_exp  [21];
  bit          s_ovf  [21];
  bit          s_vld  [21];

  initial begin
    logic [31:0] exp_rot;
    logic [31:0] exp_inv;
    int          a, b;

    rst = 1'b1; ien = 1'b0; iinv = 1'b0; iaddr = '0; idata = '0;
    step(); step();
    chk("rst_oen",   32'(oen),   32'd0);
    chk("rst_oaddr", 32'(oaddr), 32'd0);
    chk("rst_odata", odata,      32'd0);
    chk("rst_oovf",  32'(oovf),  32'd0);
    rst = 1'b0;
    step();

`ifdef FTROT_ROUND_EN
    exp_rot = {16'd1000, 16'd0};
    exp_inv = {16'd0, 16'd1000};
`else
    exp_rot = {16'd999, 16'd0};
    exp_inv = {16'd0, 16'd999};
`endif

    single("bypass", 4'b0001, {16'(1000), 16'(-2000)}, 1'b0, {16'(1000), 16'(-2000)}, 1'b0);
    single("rot_mj", 4'b0110, {16'(0), 16'(1000)},     1'b0, exp_rot, 1'b0);
    single("inv_pj", 4'b0110, {16'(1000), 16'(0)},     1'b1, exp_inv, 1'b0);
    single("sat",    4'b1010, {16'(-32768), 16'(-32768)}, 1'b0, {16'(-32768), 16'(0)}, 1'b1);
    step(); step();
    chk("hold_oen",   32'(oen),  32'd0);
    chk("hold_odata", odata,     {16'(-32768), 16'(0)});
    chk("hold_oovf",  32'(oovf), 32'd1);

    // Streaming: 16 back-to-back, 3-cycle gap, 2 more.
    for (int i = 0; i < 21; i++) begin
      if (i < 16) begin
        s_vld[i] = 1'b1; s_addr[i] = 4'(i); a = i * 1000 - 8000; b = 3000 - i * 500;
      end else if (i < 19) begin
        s_vld[i] = 1'b0; s_addr[i] = '0; a = 0; b = 0;
      end else begin
        s_vld[i] = 1'b1; s_addr[i] = (i == 19) ? 4'd5 : 4'd14; a = 12345; b = -23456;
      end
      s_dat[i] = {16'(a), 16'(b)};
      s_exp[i] = model(int'(s_addr[i]), a, b, 1'b0, s_ovf[i]);
    end
    for (int c = 0; c < 30; c++) begin
      if (c < 21 && s_vld[c]) begin
        ien = 1'b1; iaddr = s_addr[c]; idata = s_dat[c]; iinv = 1'b0;
      end else begin
        ien = 1'b0;
      end
      if (c >= 5 && c < 26 && s_vld[c-5]) begin
        chk($sformatf("strm%0d_oen", c),   32'(oen),   32'd1);
        chk($sformatf("strm%0d_oaddr", c), 32'(oaddr), 32'(s_addr[c-5]));
        chk($sformatf("strm%0d_odata", c), odata,      s_exp[c-5]);
        chk($sformatf("strm%0d_oovf", c),  32'(oovf),  32'(s_ovf[c-5]));
      end else begin
        chk($sformatf("strm%0d_oen", c), 32'(oen), 32'd0);
        if (c >= 21 && c < 24) begin
          chk($sformatf("gap%0d_odata", c), odata,      s_exp[15]);
          chk($sformatf("gap%0d_oaddr", c), 32'(oaddr), 32'd15);
        end
      end
      step();
    end

    // Reset with three samples in flight.
    for (int c = 0; c < 3; c++) begin
      ien = 1'b1; iaddr = 4'(c + 1); idata = {16'(100 * (c + 1)), 16'(7)}; iinv = 1'b0;
      step();
    end
    ien = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_oen",   32'(oen),   32'd0);
    chk("mrst_oaddr", 32'(oaddr), 32'd0);
    chk("mrst_odata", odata,      32'd0);
    chk("mrst_oovf",  32'(oovf),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("flush%0d_oen", c), 32'(oen), 32'd0);
    end
    single("post_rst", 4'b0011, {16'(-5), 16'(321)}, 1'b1, {16'(-5), 16'(321)}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
